// File: rtl/data_mem_access_pkg.sv
// Shared definitions for the data-memory access stage and the upstream
// memory-control decode: access sizes, FSM states, access opcodes.
package data_mem_access_pkg;

    localparam logic [1:0] WORD          = 2'b00;
    localparam logic [1:0] HALF          = 2'b01;
    localparam logic [1:0] BYTE          = 2'b10;
    localparam logic [1:0] INPROPER_SIZE = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    typedef enum logic {
        LOAD  = 1'b0,
        STORE = 1'b1
    } mem_op_t;

    function automatic logic size_fault(input logic [1:0] size, input logic [1:0] off);
        return (size == HALF && off[0]) || (size == WORD && off != 2'b00) ||
               (size == INPROPER_SIZE);
    endfunction

endpackage

// File: rtl/data_mem_access_load_align_extend.sv
// Lane select and sign/zero extension of a loaded word; also usable by
// the writeback stage.
module load_align_extend
    import data_mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  byte_off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (byte_off)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = byte_off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            BYTE:    result = {{24{byte_lane[7] & ~is_unsigned}}, byte_lane};
            HALF:    result = {{16{half_lane[15] & ~is_unsigned}}, half_lane};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/data_mem_access.sv
// Memory-stage load/store unit: issues one transfer per instruction on a
// ready-based bus, handles wait states, timeout, flush and load extension.
module data_mem_access
    import data_mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned XLEN           = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            require_mem_access,
    input  logic            write_to_data_mem,
    input  logic [1:0]      access_size,
    input  logic [2:0]      funct3,
    input  logic            flush,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] store_data,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_wstrb,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            stall,
    output logic [XLEN-1:0] load_data,
    output logic            load_valid,
    output logic            misaligned,
    output logic            bus_error
);
    localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned      CNT_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(CNT_LAST);

    state_t           state, next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic             drop;
    mem_op_t          op_q;
    logic [1:0]       size_q;
    logic [1:0]       off_q;
    logic             unsigned_q;

    logic             fault, start, timeout_hit, drop_now;
    logic [3:0]       wstrb_n;
    logic [XLEN-1:0]  wdata_n;
    logic [31:0]      ext_data;

    load_align_extend u_align (
        .rdata       (mem_rdata),
        .byte_off    (off_q),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .result      (ext_data)
    );

    always_comb begin
        fault       = size_fault(access_size, addr[1:0]);
        start       = require_mem_access & ~flush & ~fault;
        timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_END);
        drop_now    = drop | flush;
        next_state  = state;
        stall       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = WAIT;
                    stall      = 1'b1;
                end
            end
            WAIT: begin
                stall = 1'b1;
                // A squashed access still finishes on the bus but skips RESP.
                if (mem_ready || timeout_hit)
                    next_state = drop_now ? IDLE : RESP;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        case (access_size)
            BYTE: begin
                wdata_n = {4{store_data[7:0]}};
                wstrb_n = 4'b0001 << addr[1:0];
            end
            HALF: begin
                wdata_n = {2{store_data[15:0]}};
                wstrb_n = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata_n = store_data;
                wstrb_n = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wstrb  <= '0;
            mem_wdata  <= '0;
            load_data  <= '0;
            load_valid <= 1'b0;
            misaligned <= 1'b0;
            bus_error  <= 1'b0;
            wait_cnt   <= '0;
            drop       <= 1'b0;
            op_q       <= LOAD;
            size_q     <= WORD;
            off_q      <= 2'b00;
            unsigned_q <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            bus_error  <= 1'b0;
            misaligned <= (state == IDLE) & require_mem_access & ~flush & fault;
            case (state)
                IDLE: begin
                    if (start) begin
                        mem_req    <= 1'b1;
                        mem_we     <= write_to_data_mem;
                        mem_addr   <= {addr[XLEN-1:2], 2'b00};
                        mem_wstrb  <= write_to_data_mem ? wstrb_n : 4'b0000;
                        mem_wdata  <= wdata_n;
                        wait_cnt   <= '0;
                        drop       <= 1'b0;
                        op_q       <= write_to_data_mem ? STORE : LOAD;
                        size_q     <= access_size;
                        off_q      <= addr[1:0];
                        unsigned_q <= funct3[2];
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (flush) drop <= 1'b1;
                    if (mem_ready) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= '0;
                        if (op_q == LOAD && !drop_now) begin
                            load_data  <= ext_data;
                            load_valid <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= '0;
                        bus_error <= ~drop_now;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_access.sv
// Randomised self-checking bench for data_mem_access against a byte-level
// reference model of the load/store rules.
module tb_data_mem_access;
    import data_mem_access_pkg::*;

    localparam int unsigned TOUT = 4;

    logic        clk = 1'b0;
    logic        rst, require_mem_access, write_to_data_mem, flush, mem_ready;
    logic [1:0]  access_size;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data, mem_rdata;
    logic        mem_req, mem_we, stall, load_valid, misaligned, bus_error;
    logic [31:0] mem_addr, mem_wdata, load_data;
    logic [3:0]  mem_wstrb;

    data_mem_access #(.TIMEOUT_CYCLES(TOUT), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .require_mem_access(require_mem_access),
        .write_to_data_mem(write_to_data_mem), .access_size(access_size),
        .funct3(funct3), .flush(flush), .addr(addr), .store_data(store_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .stall(stall), .load_data(load_data),
        .load_valid(load_valid), .misaligned(misaligned), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int          n_req, n_stall, n_lv, n_mis, n_be;
    logic [31:0] ld_obs, cap_addr, cap_wdata;
    logic [3:0]  cap_wstrb;
    logic        cap_we, got_req;

    function automatic int unsigned nbytes(input logic [1:0] size);
        if (size == BYTE) return 1;
        if (size == HALF) return 2;
        return 4;
    endfunction

    function automatic logic exp_fault(input logic [1:0] size, input logic [31:0] a);
        return (size == INPROPER_SIZE) || ((a[1:0] % nbytes(size)) != 0);
    endfunction

    function automatic logic [3:0] exp_strb(input logic [1:0] size, input logic [31:0] a);
        int unsigned s;
        s = ((32'd1 << nbytes(size)) - 1) << a[1:0];
        return s[3:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] size, input logic [31:0] sd);
        if (nbytes(size) == 1) return {24'b0, sd[7:0]} * 32'h0101_0101;
        if (nbytes(size) == 2) return {16'b0, sd[15:0]} * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] rd, input logic [31:0] a,
                                             input logic [1:0] size, input logic [2:0] f3);
        int unsigned nb;
        logic [31:0] mask, v;
        nb = nbytes(size);
        if (nb == 4) return rd;
        mask = (32'h1 << (8 * nb)) - 32'h1;
        v = (rd >> (8 * a[1:0])) & mask;
        if (!f3[2] && v[8 * nb - 1]) v = v | ~mask;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one instruction until the pipeline would advance, then idles
    // three more cycles, recording everything the DUT produced.
    task automatic do_access(input logic we, input logic [1:0] size, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] sd, input int ready_at,
                             input logic [31:0] rd, input int flush_at);
        int widx = 0;
        int tail = 0;
        int guard = 0;
        bit done = 0;
        bit rel = 0;
        n_req = 0; n_stall = 0; n_lv = 0; n_mis = 0; n_be = 0;
        ld_obs = '0; cap_addr = '0; cap_wdata = '0; cap_wstrb = '0; cap_we = 0; got_req = 0;
        require_mem_access = 1; write_to_data_mem = we; access_size = size; funct3 = f3;
        addr = a; store_data = sd; flush = 0; mem_ready = 0; mem_rdata = $urandom;
        #1;
        if (stall) n_stall++; else begin done = 1; rel = 1; end
        while (tail < 3) begin
            step();
            if (rel) begin require_mem_access = 0; write_to_data_mem = 0; rel = 0; end
            if (done) tail++;
            guard++;
            if (guard > 60) begin
                checks++; failures++;
                $display("FAIL access_bound: stall still high after %0d cycles, required completion", guard);
                break;
            end
            if (mem_req) begin
                n_req++;
                if (!got_req) begin
                    got_req = 1; cap_addr = mem_addr; cap_wdata = mem_wdata;
                    cap_wstrb = mem_wstrb; cap_we = mem_we;
                end
            end
            if (load_valid) begin n_lv++; ld_obs = load_data; end
            if (misaligned) n_mis++;
            if (bus_error) n_be++;
            if (!done) begin
                if (flush_at >= 0 && widx > flush_at) begin
                    require_mem_access = 0; write_to_data_mem = 0;
                end
                mem_ready = mem_req && (ready_at >= 0) && (widx == ready_at);
                mem_rdata = mem_ready ? rd : $urandom;
                flush = mem_req && (widx == flush_at);
                if (mem_req) widx++;
                #1;
                if (stall) n_stall++; else begin done = 1; rel = 1; end
            end else begin
                flush = 0;
                mem_ready = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
        end
        mem_ready = 0; flush = 0;
    endtask

    task automatic test_reset();
        rst = 1; require_mem_access = 0; write_to_data_mem = 0; access_size = WORD;
        funct3 = 3'b010; flush = 0; addr = '0; store_data = '0; mem_ready = 1; mem_rdata = '1;
        step(); step();
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, load_data, load_valid,
             misaligned, bus_error} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: req=%b we=%b addr=%h strb=%b wdata=%h ld=%h lv=%b mis=%b be=%b, required all 0",
                     mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, load_data, load_valid, misaligned, bus_error);
        end
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", stall); end
        rst = 0; mem_ready = 0;
        step();
    endtask

    task automatic test_store();
        do_access(1, BYTE, 3'b000, 32'h0000_0103, 32'hAABB_CCDD, 0, 32'h0, -1);
        checks++;
        if (cap_addr !== 32'h0000_0100) begin failures++; $display("FAIL sb_addr: got %h expected %h", cap_addr, 32'h100); end
        checks++;
        if (cap_wstrb !== exp_strb(BYTE, 32'h103)) begin failures++; $display("FAIL sb_wstrb: got %b expected %b", cap_wstrb, exp_strb(BYTE, 32'h103)); end
        checks++;
        if (cap_wdata !== exp_wdata(BYTE, 32'hAABB_CCDD)) begin failures++; $display("FAIL sb_wdata: got %h expected %h", cap_wdata, exp_wdata(BYTE, 32'hAABB_CCDD)); end
        checks++;
        if (cap_we !== 1'b1) begin failures++; $display("FAIL sb_we: got %b expected 1", cap_we); end
        checks++;
        if (n_stall != 2) begin failures++; $display("FAIL sb_stall_cycles: got %0d expected 2", n_stall); end
        checks++;
        if (n_lv != 0) begin failures++; $display("FAIL sb_no_load_valid: got %0d expected 0", n_lv); end
    endtask

    task automatic test_load();
        logic [2:0]  f3s [3] = '{3'b001, 3'b101, 3'b000};
        logic [31:0] as  [3] = '{32'h0000_0102, 32'h0000_0102, 32'h0000_0101};
        logic [1:0]  szs [3] = '{HALF, HALF, BYTE};
        logic [31:0] exp;
        for (int i = 0; i < 3; i++) begin
            do_access(0, szs[i], f3s[i], as[i], 32'h0, 3, 32'h8001_1234, -1);
            exp = exp_load(32'h8001_1234, as[i], szs[i], f3s[i]);
            checks++;
            if (n_lv != 1 || ld_obs !== exp) begin
                failures++;
                $display("FAIL load_%0d_data: got valid=%0d data=%h expected valid=1 data=%h", i, n_lv, ld_obs, exp);
            end
            checks++;
            if (n_stall != 5 || n_req != 4) begin
                failures++;
                $display("FAIL load_%0d_latency: got stall=%0d req=%0d expected stall=5 req=4", i, n_stall, n_req);
            end
            checks++;
            if (cap_we !== 1'b0 || cap_wstrb !== 4'b0000) begin
                failures++;
                $display("FAIL load_%0d_strobe: got we=%b strb=%b expected we=0 strb=0000", i, cap_we, cap_wstrb);
            end
        end
    endtask

    task automatic test_misaligned();
        do_access(0, WORD, 3'b010, 32'h0000_0101, 32'h0, 0, 32'h0, -1);
        checks++;
        if (n_mis != 1 || n_req != 0 || n_stall != 0) begin
            failures++;
            $display("FAIL lw_misaligned: got mis=%0d req=%0d stall=%0d expected 1/0/0", n_mis, n_req, n_stall);
        end
        do_access(1, INPROPER_SIZE, 3'b000, 32'h0000_0200, 32'h1234, 0, 32'h0, -1);
        checks++;
        if (n_mis != 1 || n_req != 0 || n_stall != 0) begin
            failures++;
            $display("FAIL improper_size: got mis=%0d req=%0d stall=%0d expected 1/0/0", n_mis, n_req, n_stall);
        end
    endtask

    task automatic test_timeout();
        do_access(0, WORD, 3'b010, 32'h0000_0040, 32'h0, -1, 32'h0, -1);
        checks++;
        if (n_req != int'(TOUT) || n_be != 1 || n_lv != 0 || n_stall != int'(TOUT) + 1) begin
            failures++;
            $display("FAIL timeout: got req=%0d be=%0d lv=%0d stall=%0d expected %0d/1/0/%0d",
                     n_req, n_be, n_lv, n_stall, TOUT, TOUT + 1);
        end
    endtask

    task automatic test_flush();
        do_access(0, WORD, 3'b010, 32'h0000_0080, 32'h0, 3, 32'hCAFE_F00D, 1);
        checks++;
        if (n_req != 4 || n_stall != 5 || n_lv != 0 || n_be != 0) begin
            failures++;
            $display("FAIL flush_wait: got req=%0d stall=%0d lv=%0d be=%0d expected 4/5/0/0", n_req, n_stall, n_lv, n_be);
        end
        do_access(0, WORD, 3'b010, 32'h0000_0084, 32'h0, -1, 32'h0, 0);
        checks++;
        if (n_req != int'(TOUT) || n_be != 0 || n_lv != 0) begin
            failures++;
            $display("FAIL flush_timeout: got req=%0d be=%0d lv=%0d expected %0d/0/0", n_req, n_be, n_lv, TOUT);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, sd;
        rd = $urandom; sd = $urandom;
        require_mem_access = 1; write_to_data_mem = 0; access_size = WORD; funct3 = 3'b010;
        addr = 32'h0000_0010; store_data = '0; flush = 0; mem_ready = 0;
        step();
        mem_ready = 1; mem_rdata = rd;
        step();
        mem_ready = 0;
        checks++;
        if (load_valid !== 1'b1 || load_data !== rd || mem_req !== 1'b0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL b2b_resp: got lv=%b ld=%h req=%b stall=%b expected 1/%h/0/0", load_valid, load_data, mem_req, stall, rd);
        end
        step();
        write_to_data_mem = 1; addr = 32'h0000_0014; store_data = sd;
        #1;
        checks++;
        if (stall !== 1'b1 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle: got stall=%b req=%b expected 1/0", stall, mem_req);
        end
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h14 || mem_wdata !== sd || mem_wstrb !== 4'b1111) begin
            failures++;
            $display("FAIL b2b_second_req: got req=%b we=%b addr=%h wdata=%h strb=%b expected 1/1/14/%h/1111",
                     mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, sd);
        end
        mem_ready = 1;
        step();
        mem_ready = 0;
        step();
        require_mem_access = 0; write_to_data_mem = 0;
        step();
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd;
        rd = $urandom;
        require_mem_access = 1; write_to_data_mem = 0; access_size = WORD; funct3 = 3'b010;
        addr = 32'h0000_0020; flush = 0; mem_ready = 0;
        step();
        checks++;
        if (mem_req !== 1'b1) begin failures++; $display("FAIL rst_wait_req: got %b expected 1", mem_req); end
        step();
        rst = 1; require_mem_access = 0;
        step();
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, load_data, load_valid,
             misaligned, bus_error, stall} !== '0) begin
            failures++;
            $display("FAIL rst_mid_wait: got req=%b we=%b addr=%h strb=%b lv=%b be=%b stall=%b, required all 0",
                     mem_req, mem_we, mem_addr, mem_wstrb, load_valid, bus_error, stall);
        end
        rst = 0;
        do_access(0, WORD, 3'b010, 32'h0000_0024, 32'h0, 1, rd, -1);
        checks++;
        if (n_lv != 1 || ld_obs !== rd || n_stall != 3) begin
            failures++;
            $display("FAIL rst_then_lw: got lv=%0d ld=%h stall=%0d expected 1/%h/3", n_lv, ld_obs, n_stall, rd);
        end
    endtask

    task automatic test_random();
        logic        we, flt;
        logic [1:0]  sz;
        logic [2:0]  f3;
        logic [31:0] a, sd, rd;
        int          d;
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 3)); f3 = 3'($urandom);
            a = $urandom; sd = $urandom; rd = $urandom; d = $urandom_range(0, 3);
            flt = exp_fault(sz, a);
            do_access(we, sz, f3, a, sd, d, rd, -1);
            checks++;
            if (n_mis != int'(flt) || n_req != (flt ? 0 : d + 1) || n_stall != (flt ? 0 : d + 2)) begin
                failures++;
                $display("FAIL rand_%0d_flow: got mis=%0d req=%0d stall=%0d expected %0d/%0d/%0d",
                         i, n_mis, n_req, n_stall, flt, flt ? 0 : d + 1, flt ? 0 : d + 2);
            end
            if (!flt) begin
                checks++;
                if (cap_addr !== (a & 32'hFFFF_FFFC) || cap_we !== we ||
                    cap_wstrb !== (we ? exp_strb(sz, a) : 4'b0000)) begin
                    failures++;
                    $display("FAIL rand_%0d_bus: got addr=%h we=%b strb=%b expected %h/%b/%b",
                             i, cap_addr, cap_we, cap_wstrb, a & 32'hFFFF_FFFC, we, we ? exp_strb(sz, a) : 4'b0000);
                end
                checks++;
                if (we ? (cap_wdata !== exp_wdata(sz, sd) || n_lv != 0)
                       : (n_lv != 1 || ld_obs !== exp_load(rd, a, sz, f3))) begin
                    failures++;
                    $display("FAIL rand_%0d_data: got we=%b wdata=%h lv=%0d ld=%h expected wdata=%h ld=%h",
                             i, we, cap_wdata, n_lv, ld_obs, exp_wdata(sz, sd), exp_load(rd, a, sz, f3));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_misaligned();
        test_timeout();
        test_flush();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1);
    end

endmodule
